// File: rtl/change_dispenser.sv
// Refund controller for a vending machine: on a refund request it pays out the
// pending credit as dollar coins first, then quarters, through a handshaked coin hopper.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refund,
    input  logic [7:0] credit,
    input  logic       hopper_ready,
    output logic       clear_credit,
    output logic       dispense_dollar,
    output logic       dispense_quarter,
    output logic [6:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PULSE,
        DONE,
        FAULT
    } state_t;

    state_t     state;
    logic       refund_prev;
    logic       armed;
    logic [3:0] pulse_cnt;
    logic [7:0] wait_cnt;
    logic       refund_edge;

    // armed stays low until refund is seen low, so a button held through reset is not an edge
    assign refund_edge = refund & ~refund_prev & armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            refund_prev      <= 1'b0;
            armed            <= 1'b0;
            pulse_cnt        <= '0;
            wait_cnt         <= '0;
            remaining        <= '0;
            clear_credit     <= 1'b0;
            dispense_dollar  <= 1'b0;
            dispense_quarter <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
        end else begin
            refund_prev  <= refund;
            clear_credit <= 1'b0;
            done         <= 1'b0;
            if (!refund) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (refund_edge) begin
                        busy <= 1'b1;
                        if (credit[7]) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else if (credit == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= CHECK;
                            remaining    <= credit[6:0];
                            clear_credit <= 1'b1;
                            pulse_cnt    <= '0;
                            wait_cnt     <= '0;
                        end
                    end
                end

                CHECK: begin
                    if (remaining == 7'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (hopper_ready) begin
                        // Coin choice is latched into the dispense outputs for the whole pulse
                        state            <= PULSE;
                        pulse_cnt        <= '0;
                        wait_cnt         <= '0;
                        dispense_dollar  <= (remaining >= 7'd4);
                        dispense_quarter <= (remaining < 7'd4);
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                PULSE: begin
                    if (pulse_cnt == 4'(PULSE_CYCLES - 1)) begin
                        state            <= CHECK;
                        dispense_dollar  <= 1'b0;
                        dispense_quarter <= 1'b0;
                        remaining        <= remaining - (dispense_dollar ? 7'd4 : 7'd1);
                    end else begin
                        pulse_cnt <= pulse_cnt + 4'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                FAULT: begin
                    fault            <= 1'b1;
                    busy             <= 1'b1;
                    dispense_dollar  <= 1'b0;
                    dispense_quarter <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: cycle-by-cycle vector table plus a
// hand-written refund sequence that measures payout latency.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       refund;
    logic [7:0] credit;
    logic       hopper_ready;
    logic       clear_credit;
    logic       dispense_dollar;
    logic       dispense_quarter;
    logic [6:0] remaining;
    logic       busy;
    logic       done;
    logic       fault;

    int checks   = 0;
    int failures = 0;
    bit running  = 1'b0;

    always #5 clk = ~clk;

    change_dispenser #(
        .PULSE_CYCLES(4),
        .TIMEOUT     (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .refund          (refund),
        .credit          (credit),
        .hopper_ready    (hopper_ready),
        .clear_credit    (clear_credit),
        .dispense_dollar (dispense_dollar),
        .dispense_quarter(dispense_quarter),
        .remaining       (remaining),
        .busy            (busy),
        .done            (done),
        .fault           (fault)
    );

    // Expected output word: {clear, dollar, quarter, remaining[6:0], busy, done, fault}
    typedef struct {
        logic        rst;
        logic        refund;
        logic [7:0]  credit;
        logic        ready;
        int          reps;
        logic [12:0] expect_out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic rf, input logic [7:0] c,
                                input logic rd, input int n,
                                input logic ec, input logic edd, input logic edq,
                                input logic [6:0] erem, input logic eb, input logic ed,
                                input logic ef);
        vec_t v;
        v.rst        = r;
        v.refund     = rf;
        v.credit     = c;
        v.ready      = rd;
        v.reps       = n;
        v.expect_out = {ec, edd, edq, erem, eb, ed, ef};
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic rf, input logic [7:0] c,
                                 input logic rd);
        rst          = r;
        refund       = rf;
        credit       = c;
        hopper_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [12:0] expect_out);
        logic [12:0] actual;
        actual = {clear_credit, dispense_dollar, dispense_quarter, remaining, busy, done, fault};
        checks++;
        if (actual !== expect_out) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got clr/dd/dq/rem/busy/done/fault=%b/%b/%b/%0d/%b/%b/%b, wanted %b/%b/%b/%0d/%b/%b/%b",
                     name, idx, actual[12], actual[11], actual[10], actual[9:3], actual[2],
                     actual[1], actual[0], expect_out[12], expect_out[11], expect_out[10],
                     expect_out[9:3], expect_out[2], expect_out[1], expect_out[0]);
        end
    endtask

    // Both coin commands at once would jam the hopper
    always @(negedge clk) begin
        if (running) begin
            checks++;
            if (dispense_dollar && dispense_quarter) begin
                failures++;
                $display("[TB] FAIL exclusive: dollar=%b quarter=%b, wanted not both high",
                         dispense_dollar, dispense_quarter);
            end
        end
    end

    initial begin
        int cycles;
        int quarter_cycles;
        int dollar_cycles;

        rst = 1'b1; refund = 1'b0; credit = 8'd0; hopper_ready = 1'b1;

        // Reset state
        add(1, 0, 8'd0, 1, 2,   0, 0, 0, 7'd0, 0, 0, 0);
        // credit=7: one dollar then three quarters
        add(0, 0, 8'd7, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        add(0, 1, 8'd7, 1, 1,   1, 0, 0, 7'd7, 1, 0, 0);
        add(0, 1, 8'd7, 1, 4,   0, 1, 0, 7'd7, 1, 0, 0);
        add(0, 1, 8'd7, 1, 1,   0, 0, 0, 7'd3, 1, 0, 0);
        add(0, 1, 8'd7, 1, 4,   0, 0, 1, 7'd3, 1, 0, 0);
        add(0, 1, 8'd7, 1, 1,   0, 0, 0, 7'd2, 1, 0, 0);
        add(0, 1, 8'd7, 1, 4,   0, 0, 1, 7'd2, 1, 0, 0);
        add(0, 1, 8'd7, 1, 1,   0, 0, 0, 7'd1, 1, 0, 0);
        add(0, 1, 8'd7, 1, 4,   0, 0, 1, 7'd1, 1, 0, 0);
        add(0, 1, 8'd7, 1, 1,   0, 0, 0, 7'd0, 1, 0, 0);
        add(0, 1, 8'd7, 1, 1,   0, 0, 0, 7'd0, 1, 1, 0);
        add(0, 1, 8'd7, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        // credit=0: straight to done
        add(0, 0, 8'd0, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        add(0, 1, 8'd0, 1, 1,   0, 0, 0, 7'd0, 1, 1, 0);
        add(0, 1, 8'd0, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        // credit=-3: sticky fault, refund edges ignored, reset clears
        add(0, 0, 8'hFD, 1, 1,  0, 0, 0, 7'd0, 0, 0, 0);
        add(0, 1, 8'hFD, 1, 1,  0, 0, 0, 7'd0, 1, 0, 1);
        add(0, 0, 8'hFD, 1, 100, 0, 0, 0, 7'd0, 1, 0, 1);
        add(0, 1, 8'hFD, 1, 1,  0, 0, 0, 7'd0, 1, 0, 1);
        add(1, 0, 8'hFD, 1, 1,  0, 0, 0, 7'd0, 0, 0, 0);
        // credit=4 with hopper never ready: timeout after 16 CHECK cycles
        add(0, 0, 8'd4, 0, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        add(0, 1, 8'd4, 0, 1,   1, 0, 0, 7'd4, 1, 0, 0);
        add(0, 1, 8'd4, 0, 15,  0, 0, 0, 7'd4, 1, 0, 0);
        add(0, 1, 8'd4, 0, 3,   0, 0, 0, 7'd4, 1, 0, 1);
        add(1, 0, 8'd0, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        // credit=5: reset on the 2nd dollar-pulse cycle, refund held through release
        add(0, 0, 8'd5, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        add(0, 1, 8'd5, 1, 1,   1, 0, 0, 7'd5, 1, 0, 0);
        add(0, 1, 8'd5, 1, 2,   0, 1, 0, 7'd5, 1, 0, 0);
        add(1, 1, 8'd5, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        add(0, 1, 8'd5, 1, 3,   0, 0, 0, 7'd0, 0, 0, 0);
        add(0, 0, 8'd5, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);
        // credit=8: re-toggled refund and dropped hopper_ready mid-pulse are ignored
        add(0, 1, 8'd8, 1, 1,   1, 0, 0, 7'd8, 1, 0, 0);
        add(0, 1, 8'd8, 1, 1,   0, 1, 0, 7'd8, 1, 0, 0);
        add(0, 0, 8'd8, 0, 1,   0, 1, 0, 7'd8, 1, 0, 0);
        add(0, 1, 8'd8, 0, 2,   0, 1, 0, 7'd8, 1, 0, 0);
        add(0, 1, 8'd8, 1, 1,   0, 0, 0, 7'd4, 1, 0, 0);
        add(0, 1, 8'd8, 1, 4,   0, 1, 0, 7'd4, 1, 0, 0);
        add(0, 1, 8'd8, 1, 1,   0, 0, 0, 7'd0, 1, 0, 0);
        add(0, 1, 8'd8, 1, 1,   0, 0, 0, 7'd0, 1, 1, 0);
        add(0, 0, 8'd8, 1, 1,   0, 0, 0, 7'd0, 0, 0, 0);

        running = 1'b1;
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].reps; k++) begin
                applyStimulus(vecs[i].rst, vecs[i].refund, vecs[i].credit, vecs[i].ready);
                checkOutput("vector", i, vecs[i].expect_out);
            end
        end

        // credit=2: two quarters, done expected 1 + 2*(4+1) cycles after the edge
        applyStimulus(1'b0, 1'b0, 8'd2, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b1);
        cycles = 0;
        quarter_cycles = 0;
        dollar_cycles = 0;
        while (!done && cycles < 40) begin
            applyStimulus(1'b0, 1'b1, 8'd2, 1'b1);
            cycles++;
            if (dispense_quarter) quarter_cycles++;
            if (dispense_dollar) dollar_cycles++;
        end
        checks++;
        if (cycles != 11) begin
            failures++;
            $display("[TB] FAIL latency: done after %0d cycles, wanted 11", cycles);
        end
        checks++;
        if (quarter_cycles != 8) begin
            failures++;
            $display("[TB] FAIL quarter_cycles: got %0d, wanted 8", quarter_cycles);
        end
        checks++;
        if (dollar_cycles != 0) begin
            failures++;
            $display("[TB] FAIL dollar_cycles: got %0d, wanted 0", dollar_cycles);
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("after_latency", 0, 13'd0);

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
